// File: rtl/progloader.sv
// Program-memory loader: takes a length-prefixed, big-endian byte stream and
// writes each assembled 32-bit word into the instruction memory, holding the CPU meanwhile.
module progloader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [31:0]   wd,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_BYTE, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q,   len_d;
  logic [AW:0] idx_q,   idx_d;   // one extra bit so a full DEPTH count is representable
  logic [1:0]  bcnt_q,  bcnt_d;
  logic [31:0] asm_q,   asm_d;

  logic        xfer;
  logic [15:0] len_full;

  assign xfer     = in_valid & in_ready;
  assign len_full = {len_q[15:8], in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == 16'd0)             state_d = S_DONE;
          else if (len_full > 16'(DEPTH))    state_d = S_ERROR;
          else                               state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        if (xfer) begin
          asm_d  = {asm_q[23:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (16'(idx_q) == len_q - 16'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_BYTE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All status outputs decode registered state only.
  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_BYTE);
  assign busy     = in_ready || (state_q == S_WRITE);
  assign cpu_hold = busy || (state_q == S_ERROR);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERROR);
  assign we       = (state_q == S_WRITE);
  assign wa       = idx_q[AW-1:0];
  assign wd       = asm_q;

endmodule

// File: tb/tb_progloader.sv
// Directed bench for progloader: drives byte streams and checks the write log
// and status levels against hand-computed values.
module tb_progloader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, we, cpu_hold, busy, done, error;
  logic [9:0]  wa;
  logic [31:0] wd;

  progloader #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .wa(wa), .wd(wd), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // write log captured mid-cycle
  int          nw = 0;
  logic [9:0]  log_a [64];
  logic [31:0] log_d [64];
  int          log_c [64];
  always @(negedge clk) begin
    if (we && nw < 64) begin
      log_a[nw] <= wa;
      log_d[nw] <= wd;
      log_c[nw] <= cyc;
      nw        <= nw + 1;
    end
  end

  logic [7:0] stream [16];
  int         waits  [16];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends stream[0..n-1]; gap idle cycles after each byte; start raised with byte start_at.
  task automatic send(input int n, input int gap, input int start_at);
    for (int i = 0; i < n; i++) begin
      int w;
      w        = 0;
      in_valid = 1'b1;
      in_data  = stream[i];
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) chk("handshake_timeout", 32'(w), 32'd0);
      waits[i] = w;
      if (i == start_at) start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic load_basic_stream();
    stream[0] = 8'h00; stream[1] = 8'h02;
    stream[2] = 8'hDE; stream[3] = 8'hAD; stream[4] = 8'hBE; stream[5] = 8'hEF;
    stream[6] = 8'h01; stream[7] = 8'h23; stream[8] = 8'h45; stream[9] = 8'h67;
  endtask

  task automatic check_two_words(input string tag, input int base, input bit timed);
    chk({tag, "_nwrites"}, 32'(nw - base), 32'd2);
    chk({tag, "_wa0"}, 32'(log_a[base]),   32'd0);
    chk({tag, "_wd0"}, log_d[base],         32'hDEADBEEF);
    chk({tag, "_wa1"}, 32'(log_a[base+1]), 32'd1);
    chk({tag, "_wd1"}, log_d[base+1],       32'h01234567);
    if (timed) chk({tag, "_spacing"}, 32'(log_c[base+1] - log_c[base]), 32'd5);
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_we",       32'(we),       0);
    chk("rst_wa",       32'(wa),       0);
    chk("rst_wd",       wd,            0);
    chk("rst_hold",     32'(cpu_hold), 0);
    chk("rst_busy",     32'(busy),     0);
    chk("rst_done",     32'(done),     0);
    chk("rst_error",    32'(error),    0);
    reset = 1'b0;
    tick();

    // basic load, continuous valid
    base = nw;
    load_basic_stream();
    pulse_start();
    chk("basic_ready_after_start", 32'(in_ready), 1);
    chk("basic_busy",              32'(busy),     1);
    chk("basic_hold",              32'(cpu_hold), 1);
    send(10, 0, -1);
    chk("basic_we_in_write",    32'(we),       1);
    chk("basic_ready_in_write", 32'(in_ready), 0);
    chk("basic_wait_b2",        32'(waits[2]), 0);
    chk("basic_wait_b6",        32'(waits[6]), 1);
    tick();
    chk("basic_done", 32'(done),     1);
    chk("basic_hold_off", 32'(cpu_hold), 0);
    chk("basic_busy_off", 32'(busy),     0);
    chk("basic_error", 32'(error),    0);
    check_two_words("basic", base, 1'b1);

    // zero count
    base = nw;
    stream[0] = 8'h00; stream[1] = 8'h00;
    pulse_start();
    chk("zero_done_cleared", 32'(done), 0);
    send(2, 0, -1);
    chk("zero_done",  32'(done),  1);
    chk("zero_error", 32'(error), 0);
    chk("zero_hold",  32'(cpu_hold), 0);
    tick();
    chk("zero_nwrites", 32'(nw - base), 0);

    // oversize: N = 1025
    base = nw;
    stream[0] = 8'h04; stream[1] = 8'h01;
    pulse_start();
    send(2, 0, -1);
    chk("over_error", 32'(error),    1);
    chk("over_hold",  32'(cpu_hold), 1);
    chk("over_ready", 32'(in_ready), 0);
    chk("over_done",  32'(done),     0);
    in_valid = 1'b1; in_data = 8'hAA;
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("over_still_error", 32'(error), 1);
    chk("over_nwrites", 32'(nw - base), 0);

    // reload after error
    base = nw;
    load_basic_stream();
    pulse_start();
    chk("reload_error_cleared", 32'(error), 0);
    send(10, 0, -1);
    tick();
    chk("reload_done", 32'(done), 1);
    check_two_words("reload", base, 1'b1);

    // gaps of 3 idle cycles between bytes
    base = nw;
    pulse_start();
    send(10, 3, -1);
    chk("gap_done", 32'(done), 1);
    check_two_words("gap", base, 1'b0);

    // reset after 2 bytes of word 1
    base = nw;
    pulse_start();
    send(8, 0, -1);
    reset = 1'b1;
    tick();
    chk("midrst_busy",  32'(busy),     0);
    chk("midrst_hold",  32'(cpu_hold), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    chk("midrst_we",    32'(we),       0);
    chk("midrst_wa",    32'(wa),       0);
    chk("midrst_wd",    wd,            0);
    chk("midrst_done",  32'(done),     0);
    start = 1'b1;  // reset must win over start
    tick();
    start = 1'b0;
    chk("rst_beats_start", 32'(busy), 0);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h45;
    for (int k = 0; k < 10; k++) tick();
    in_valid = 1'b0;
    chk("midrst_nwrites", 32'(nw - base), 1);
    chk("midrst_wd0", log_d[base], 32'hDEADBEEF);
    chk("midrst_idle", 32'(busy), 0);

    // start pulsed during BYTE is ignored
    base = nw;
    pulse_start();
    send(10, 0, 4);
    tick();
    chk("midstart_done", 32'(done), 1);
    check_two_words("midstart", base, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
